l2_dst_arb: RTL and testbench

- Parametrised successor to the L2 destination stage.
- Arbitrates CH_NUM generic L1 request channels onto the single L2 cache request port.
- Keeps one transaction outstanding and routes the cache response back to the originating channel.
- Adds selectable round-robin or fixed-priority arbitration and a response watchdog that returns an error status if the cache never answers.

---
 rtl/l2_dst_arb.sv | 155 +++++++++++++++
 tb/tb_l2_dst_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_dst_arb.sv
// L2 destination arbiter: grants one of CH_NUM L1 request channels onto the single
// L2 cache port, keeps one transaction outstanding and routes the response back.
module l2_dst_arb #(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned ADDR_W   = 48,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned TYPE_W   = 3,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic [CH_NUM-1:0]            i_req_valid,
  input  logic [CH_NUM*TYPE_W-1:0]     i_req_type,
  input  logic [CH_NUM*ADDR_W-1:0]     i_req_addr,
  input  logic [CH_NUM*LINE_W-1:0]     i_req_wdata,
  input  logic [CH_NUM*LINE_W/8-1:0]   i_req_wstrb,
  output logic [CH_NUM-1:0]            o_req_ready,
  output logic                         o_req_valid,
  input  logic                         i_req_ready,
  output logic [$clog2(CH_NUM)-1:0]    o_req_ch,
  output logic [TYPE_W-1:0]            o_req_type,
  output logic [ADDR_W-1:0]            o_req_addr,
  output logic [LINE_W-1:0]            o_req_wdata,
  output logic [LINE_W/8-1:0]          o_req_wstrb,
  input  logic                         i_resp_valid,
  input  logic [LINE_W-1:0]            i_resp_rdata,
  input  logic [1:0]                   i_resp_status,
  output logic [CH_NUM-1:0]            o_resp_valid,
  output logic [LINE_W-1:0]            o_resp_rdata,
  output logic [1:0]                   o_resp_status,
  output logic                         o_timeout,
  output logic                         o_stray
);

  localparam int unsigned CH_W   = $clog2(CH_NUM);
  localparam int unsigned STRB_W = LINE_W / 8;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr;
  logic [TMR_W-1:0]    timer_q;
  logic                lo_vld, hi_vld, grant_vld;
  logic [CH_W-1:0]     lo_idx, hi_idx, grant_idx;
  logic [TYPE_W-1:0]   sel_type;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LINE_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                timer_hit, timeout_fire, stray;

  // Lowest valid at/after rr_ptr (wrap falls back to lowest overall); no modulo needed.
  always_comb begin
    lo_vld = 1'b0;
    lo_idx = '0;
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int j = CH_NUM - 1; j >= 0; j--) begin
      if (i_req_valid[j]) begin
        lo_vld = 1'b1;
        lo_idx = CH_W'(j);
        if (CH_W'(j) >= rr_ptr) begin
          hi_vld = 1'b1;
          hi_idx = CH_W'(j);
        end
      end
    end
    grant_vld = lo_vld;
    grant_idx = (ARB_MODE == 0 && hi_vld) ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_type  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (grant_idx == CH_W'(k)) begin
        sel_type  = i_req_type[k*TYPE_W +: TYPE_W];
        sel_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wdata[k*LINE_W +: LINE_W];
        sel_wstrb = i_req_wstrb[k*STRB_W +: STRB_W];
      end
    end
  end

  assign o_req_ready = (state_q == IDLE && grant_vld) ? (CH_NUM'(1) << grant_idx) : '0;

  assign timer_hit    = (timer_q == TMR_W'(TIMEOUT - 1));
  assign timeout_fire = (state_q == WAIT_RESP) && !i_resp_valid && timer_hit;
  assign stray        = i_resp_valid && (state_q != WAIT_RESP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_vld) state_d = REQ;
      REQ:       if (i_req_ready) state_d = WAIT_RESP;
      WAIT_RESP: if (i_resp_valid || timer_hit) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Captured request, response latch, pointer, watchdog and registered strobes.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      rr_ptr        <= '0;
      timer_q       <= '0;
      o_req_valid   <= 1'b0;
      o_req_ch      <= '0;
      o_req_type    <= '0;
      o_req_addr    <= '0;
      o_req_wdata   <= '0;
      o_req_wstrb   <= '0;
      o_resp_valid  <= '0;
      o_resp_rdata  <= '0;
      o_resp_status <= '0;
      o_timeout     <= 1'b0;
      o_stray       <= 1'b0;
    end else begin
      o_req_valid  <= (state_d == REQ);
      o_timeout    <= timeout_fire;
      o_stray      <= stray;
      o_resp_valid <= (state_q == WAIT_RESP && state_d == RESP) ? (CH_NUM'(1) << o_req_ch) : '0;
      if (state_q == IDLE && grant_vld) begin
        o_req_ch    <= grant_idx;
        o_req_type  <= sel_type;
        o_req_addr  <= sel_addr;
        o_req_wdata <= sel_wdata;
        o_req_wstrb <= sel_wstrb;
      end
      if (state_q == REQ) timer_q <= '0;
      else if (state_q == WAIT_RESP) timer_q <= timer_q + TMR_W'(1);
      // A real response wins over the watchdog in the same cycle.
      if (state_q == WAIT_RESP) begin
        if (i_resp_valid) begin
          o_resp_rdata  <= i_resp_rdata;
          o_resp_status <= i_resp_status;
        end else if (timer_hit) begin
          o_resp_rdata  <= '0;
          o_resp_status <= 2'b11;
        end
      end
      if (state_q == RESP && ARB_MODE == 0)
        rr_ptr <= (o_req_ch == CH_W'(CH_NUM - 1)) ? '0 : o_req_ch + CH_W'(1);
    end
  end

endmodule

// File: tb/tb_l2_dst_arb.sv
// Bench for l2_dst_arb: three instances (4ch RR, 4ch fixed priority, 3ch RR) share
// stimulus; only the selected one is out of reset. A scoreboard queue holds expected responses.
module tb_l2_dst_arb;

  logic         clk;
  logic         nrst_a, nrst_b, nrst_c;
  logic [3:0]   req_valid;
  logic [11:0]  req_type;
  logic [191:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic         req_ready, resp_valid;
  logic [31:0]  resp_rdata;
  logic [1:0]   resp_status;

  logic [3:0] a_ready, a_rv, b_ready, b_rv;
  logic [2:0] c_ready, c_rv;
  logic       a_vld, a_to, a_stray, b_vld, b_to, b_stray, c_vld, c_to, c_stray;
  logic [1:0] a_ch, a_st, b_ch, b_st, c_ch, c_st;
  logic [2:0] a_type, b_type, c_type;
  logic [47:0] a_addr, b_addr, c_addr;
  logic [31:0] a_wdata, b_wdata, c_wdata, a_rd, b_rd, c_rd;
  logic [3:0]  a_wstrb, b_wstrb, c_wstrb;

  l2_dst_arb #(.CH_NUM(4), .LINE_W(32), .ARB_MODE(0), .TIMEOUT(16)) u_a (
    .i_clk(clk), .i_nrst(nrst_a), .i_req_valid(req_valid), .i_req_type(req_type),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_req_ready(a_ready), .o_req_valid(a_vld), .i_req_ready(req_ready), .o_req_ch(a_ch),
    .o_req_type(a_type), .o_req_addr(a_addr), .o_req_wdata(a_wdata), .o_req_wstrb(a_wstrb),
    .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata), .i_resp_status(resp_status),
    .o_resp_valid(a_rv), .o_resp_rdata(a_rd), .o_resp_status(a_st),
    .o_timeout(a_to), .o_stray(a_stray));

  l2_dst_arb #(.CH_NUM(4), .LINE_W(32), .ARB_MODE(1), .TIMEOUT(16)) u_b (
    .i_clk(clk), .i_nrst(nrst_b), .i_req_valid(req_valid), .i_req_type(req_type),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_req_ready(b_ready), .o_req_valid(b_vld), .i_req_ready(req_ready), .o_req_ch(b_ch),
    .o_req_type(b_type), .o_req_addr(b_addr), .o_req_wdata(b_wdata), .o_req_wstrb(b_wstrb),
    .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata), .i_resp_status(resp_status),
    .o_resp_valid(b_rv), .o_resp_rdata(b_rd), .o_resp_status(b_st),
    .o_timeout(b_to), .o_stray(b_stray));

  l2_dst_arb #(.CH_NUM(3), .LINE_W(32), .ARB_MODE(0), .TIMEOUT(1024)) u_c (
    .i_clk(clk), .i_nrst(nrst_c), .i_req_valid(req_valid[2:0]), .i_req_type(req_type[8:0]),
    .i_req_addr(req_addr[143:0]), .i_req_wdata(req_wdata[95:0]), .i_req_wstrb(req_wstrb[11:0]),
    .o_req_ready(c_ready), .o_req_valid(c_vld), .i_req_ready(req_ready), .o_req_ch(c_ch),
    .o_req_type(c_type), .o_req_addr(c_addr), .o_req_wdata(c_wdata), .o_req_wstrb(c_wstrb),
    .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata), .i_resp_status(resp_status),
    .o_resp_valid(c_rv), .o_resp_rdata(c_rd), .o_resp_status(c_st),
    .o_timeout(c_to), .o_stray(c_stray));

  // Output view of whichever instance is under test.
  int          sel;
  logic [3:0]  m_ready, m_rv;
  logic        m_vld, m_to, m_stray;
  logic [1:0]  m_ch, m_st;
  logic [2:0]  m_type;
  logic [47:0] m_addr;
  logic [31:0] m_wdata, m_rd;
  logic [3:0]  m_wstrb;

  assign {m_ready, m_vld, m_ch, m_type, m_addr, m_wdata, m_wstrb, m_rv, m_rd, m_st, m_to, m_stray} =
    (sel == 0) ? {a_ready, a_vld, a_ch, a_type, a_addr, a_wdata, a_wstrb, a_rv, a_rd, a_st, a_to, a_stray} :
    (sel == 1) ? {b_ready, b_vld, b_ch, b_type, b_addr, b_wdata, b_wstrb, b_rv, b_rd, b_st, b_to, b_stray} :
                 {1'b0, c_ready, c_vld, c_ch, c_type, c_addr, c_wdata, c_wstrb, 1'b0, c_rv, c_rd, c_st, c_to, c_stray};

  typedef struct packed {
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [1:0]  st;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [47:0] addr_tab [4];
  logic [2:0]  type_tab [4];
  logic [31:0] wd_tab   [4];
  logic [3:0]  ws_tab   [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset(input int which);
    nrst_a = 1'b0; nrst_b = 1'b0; nrst_c = 1'b0;
    req_valid = '0; req_ready = 1'b0; resp_valid = 1'b0;
    resp_rdata = '0; resp_status = '0;
    repeat (3) tick();
    sel = which;
    if (which == 0) nrst_a = 1'b1;
    else if (which == 1) nrst_b = 1'b1;
    else nrst_c = 1'b1;
  endtask

  task automatic check_resp(input logic exp_to, input bit chk_lat);
    int   n;
    exp_t e;
    n = 0;
    while (m_rv === 4'b0 && n < 50) begin tick(); n++; end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if ({m_rv, m_rd, m_st, m_to} !== {e.rv, e.rd, e.st, exp_to}) begin
      errors++;
      $display("FAIL resp: got rv=%b rd=%h st=%b to=%b, required rv=%b rd=%h st=%b to=%b",
               m_rv, m_rd, m_st, m_to, e.rv, e.rd, e.st, exp_to);
    end
    if (chk_lat) begin
      checks++;
      if (n != 0) begin
        errors++;
        $display("FAIL resp_latency: got %0d extra cycles, required 0", n);
      end
    end
  endtask

  // Cache model: wait for request, optionally stall, accept, answer after delay cycles.
  task automatic serve(input int exp_ch, input int stall, input int delay,
                       input logic [31:0] rd, input logic [1:0] st,
                       input bit oneshot, input int exp_wait);
    int   n;
    exp_t e;
    n = 0;
    while (m_vld !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (m_vld !== 1'b1 || (exp_wait >= 0 && n != exp_wait)) begin
      errors++;
      $display("FAIL req_valid: got valid=%b after %0d cycles, required 1 after %0d", m_vld, n, exp_wait);
    end
    if (oneshot) req_valid[exp_ch] = 1'b0;
    checks++;
    if (m_ch !== 2'(exp_ch)) begin
      errors++;
      $display("FAIL req_ch: got %0d, required %0d", m_ch, exp_ch);
    end
    checks++;
    if ({m_addr, m_type, m_wdata, m_wstrb} !== {addr_tab[exp_ch], type_tab[exp_ch], wd_tab[exp_ch], ws_tab[exp_ch]}) begin
      errors++;
      $display("FAIL req_fields: got addr=%h type=%h wd=%h ws=%h, required addr=%h type=%h wd=%h ws=%h",
               m_addr, m_type, m_wdata, m_wstrb, addr_tab[exp_ch], type_tab[exp_ch], wd_tab[exp_ch], ws_tab[exp_ch]);
    end
    repeat (stall) begin
      tick();
      checks++;
      if ({m_vld, m_addr} !== {1'b1, addr_tab[exp_ch]}) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b addr=%h, required 1 %h", m_vld, m_addr, addr_tab[exp_ch]);
      end
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    e.rv = 4'b0001 << exp_ch;
    e.rd = rd;
    e.st = st;
    sb.push_back(e);
    repeat (delay) tick();
    resp_valid = 1'b1; resp_rdata = rd; resp_status = st;
    tick();
    resp_valid = 1'b0;
    check_resp(1'b0, 1'b1);
  endtask

  task automatic test_reset;
    nrst_a = 1'b0; nrst_b = 1'b0; nrst_c = 1'b0; sel = 0;
    req_valid = '0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; resp_status = '0;
    repeat (10) tick();
    checks++;
    if ({m_ready, m_vld, m_ch, m_type, m_addr, m_wdata, m_wstrb, m_rv, m_rd, m_st, m_to, m_stray} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b vld=%b ch=%0d addr=%h rv=%b st=%b to=%b stray=%b, required all 0",
               m_ready, m_vld, m_ch, m_addr, m_rv, m_st, m_to, m_stray);
    end
    nrst_a = 1'b1;
    #1;
    checks++;
    if (m_ready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ready: got %b, required 0000", m_ready);
    end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (m_ready !== 4'b0010) begin
      errors++;
      $display("FAIL grant_onehot: got %b, required 0010", m_ready);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin;
    do_reset(0);
    req_valid = 4'b1010;
    serve(1, 0, 2, 32'h1111_0001, 2'b00, 1'b0, -1);
    serve(3, 0, 2, 32'h1111_0003, 2'b01, 1'b0, -1);
    serve(1, 0, 2, 32'h1111_0011, 2'b10, 1'b0, -1);
    serve(3, 0, 2, 32'h1111_0033, 2'b00, 1'b0, -1);
    req_valid = 4'b0000;
  endtask

  task automatic test_fixed_prio;
    do_reset(1);
    req_valid = 4'b0101;
    serve(0, 0, 1, 32'h2222_0000, 2'b00, 1'b0, -1);
    serve(0, 0, 1, 32'h2222_0001, 2'b00, 1'b0, -1);
    serve(0, 0, 1, 32'h2222_0002, 2'b01, 1'b1, -1);
    serve(2, 0, 1, 32'h2222_0020, 2'b10, 1'b1, -1);
  endtask

  task automatic test_backpressure;
    do_reset(0);
    req_valid = 4'b0100;
    serve(2, 5, 1, 32'h3333_0002, 2'b00, 1'b1, 1);
  endtask

  task automatic test_watchdog;
    int   n;
    exp_t e;
    do_reset(0);
    req_valid = 4'b0001;
    n = 0;
    while (m_vld !== 1'b1 && n < 50) begin tick(); n++; end
    req_valid = 4'b0000;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    e.rv = 4'b0001; e.rd = 32'h0; e.st = 2'b11;
    sb.push_back(e);
    n = 0;
    while (m_to !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles, required 16", n);
    end
    check_resp(1'b1, 1'b1);
    tick();
    checks++;
    if ({m_to, m_rv} !== 5'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got to=%b rv=%b, required 0 0000", m_to, m_rv);
    end
  endtask

  task automatic test_resp_vs_timeout;
    do_reset(0);
    req_valid = 4'b1000;
    serve(3, 0, 15, 32'h4444_0003, 2'b00, 1'b1, -1);
  endtask

  task automatic test_stray;
    do_reset(0);
    resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF; resp_status = 2'b01;
    tick();
    resp_valid = 1'b0;
    checks++;
    if ({m_stray, m_rv} !== 5'b1_0000) begin
      errors++;
      $display("FAIL stray_pulse: got stray=%b rv=%b, required 1 0000", m_stray, m_rv);
    end
    tick();
    checks++;
    if ({m_stray, m_rv, m_rd} !== 37'b0) begin
      errors++;
      $display("FAIL stray_clear: got stray=%b rv=%b rd=%h, required 0 0000 0", m_stray, m_rv, m_rd);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset(0);
    req_valid = 4'b1000;
    n = 0;
    while (m_vld !== 1'b1 && n < 50) begin tick(); n++; end
    req_valid = 4'b0000;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    nrst_a = 1'b0;
    tick();
    nrst_a = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'h5555_5555; resp_status = 2'b00;
    tick();
    resp_valid = 1'b0;
    checks++;
    if ({m_stray, m_vld, m_rv} !== 6'b10_0000) begin
      errors++;
      $display("FAIL reset_mid: got stray=%b vld=%b rv=%b, required 1 0 0000", m_stray, m_vld, m_rv);
    end
    repeat (4) begin
      tick();
      checks++;
      if (m_rv !== 4'b0) begin
        errors++;
        $display("FAIL reset_mid_noresp: got rv=%b, required 0000", m_rv);
      end
    end
  endtask

  task automatic test_ch3_wrap;
    do_reset(2);
    req_valid = 4'b0101;
    serve(0, 0, 1, 32'h6666_0000, 2'b00, 1'b0, -1);
    serve(2, 0, 1, 32'h6666_0002, 2'b01, 1'b0, -1);
    serve(0, 0, 1, 32'h6666_0010, 2'b00, 1'b0, -1);
    req_valid = 4'b0000;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      addr_tab[k] = 48'h0000_1000_0000 + 48'(k) * 48'h100;
      type_tab[k] = 3'(k + 1);
      wd_tab[k]   = 32'hA0A0_0000 | 32'(k);
      ws_tab[k]   = 4'hF ^ 4'(k);
    end
    addr_tab[2] = 48'h0000_8000_0040;
    for (int k = 0; k < 4; k++) begin
      req_addr[k*48 +: 48] = addr_tab[k];
      req_type[k*3 +: 3]   = type_tab[k];
      req_wdata[k*32 +: 32] = wd_tab[k];
      req_wstrb[k*4 +: 4]  = ws_tab[k];
    end
    test_reset();
    test_round_robin();
    test_fixed_prio();
    test_backpressure();
    test_watchdog();
    test_resp_vs_timeout();
    test_stray();
    test_reset_mid();
    test_ch3_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
